// File: rtl/btn_debouncer.sv
// Multi-button debouncer: two-flop synchronizer, shared sample prescaler,
// per-button stability counter, press/release strobes and a hold flag.
module btn_debouncer #(
   parameter int NBTN    = 8,
   parameter int CLKDIV  = 100000,
   parameter int NSTABLE = 4,
   parameter int NHOLD   = 500
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [NBTN-1:0] i_btn,
   output logic [NBTN-1:0] o_btn,
   output logic [NBTN-1:0] o_press,
   output logic [NBTN-1:0] o_release,
   output logic [NBTN-1:0] o_hold,
   output logic            o_tick
);

   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int SW = (NSTABLE > 1) ? $clog2(NSTABLE) : 1;
   localparam int HW = $clog2(NHOLD + 1);

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
   localparam logic [DW-1:0] DIV_PRE   = DW'(CLKDIV - 2);
   localparam logic [SW-1:0] STAB_LAST = SW'(NSTABLE - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(NHOLD);

   logic [NBTN-1:0] meta;
   logic [NBTN-1:0] sync;
   logic [DW-1:0]   div;

   logic [SW-1:0]   stab     [NBTN];
   logic [SW-1:0]   stab_nxt [NBTN];
   logic [HW-1:0]   hold     [NBTN];
   logic [HW-1:0]   hold_nxt [NBTN];

   logic [NBTN-1:0] differ;
   logic [NBTN-1:0] accept;
   logic [NBTN-1:0] btn_nxt;
   logic [NBTN-1:0] hold_flag;

   // o_tick is registered one cycle early so it is high exactly while div == CLKDIV-1.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         meta   <= '0;
         sync   <= '0;
         div    <= '0;
         o_tick <= 1'b0;
      end else begin
         meta   <= i_btn;
         sync   <= meta;
         div    <= (div == DIV_LAST) ? '0 : div + DW'(1);
         o_tick <= (div == DIV_PRE);
      end
   end

   always_comb begin
      stab_nxt  = stab;
      hold_nxt  = hold;
      differ    = '0;
      accept    = '0;
      btn_nxt   = o_btn;
      hold_flag = '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
         differ[i] = sync[i] ^ o_btn[i];
         accept[i] = o_tick && differ[i] && (stab[i] == STAB_LAST);

         if (!differ[i])
            stab_nxt[i] = '0;
         else if (o_tick)
            stab_nxt[i] = accept[i] ? '0 : stab[i] + SW'(1);

         btn_nxt[i] = accept[i] ? sync[i] : o_btn[i];

         if (!o_btn[i])
            hold_nxt[i] = '0;
         else if (o_tick && (hold[i] != HOLD_MAX))
            hold_nxt[i] = hold[i] + HW'(1);

         // Gating with the next level drops the flag on the same edge as the release.
         hold_flag[i] = btn_nxt[i] && (hold_nxt[i] == HOLD_MAX);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned i = 0; i < NBTN; i++) begin
            stab[i] <= '0;
            hold[i] <= '0;
         end
         o_btn     <= '0;
         o_press   <= '0;
         o_release <= '0;
         o_hold    <= '0;
      end else begin
         for (int unsigned i = 0; i < NBTN; i++) begin
            stab[i] <= stab_nxt[i];
            hold[i] <= hold_nxt[i];
         end
         o_btn     <= btn_nxt;
         o_press   <= accept & sync;
         o_release <= accept & ~sync;
         o_hold    <= hold_flag;
      end
   end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with CLKDIV=4, NSTABLE=3, NHOLD=5.
module tb_btn_debouncer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] btn = '0;
   logic [7:0] o_btn, o_press, o_release, o_hold;
   logic       o_tick;

   int checks = 0;
   int failures = 0;
   int press_cnt [8];
   int rel_cnt [8];

   always #5 clk = ~clk;

   btn_debouncer #(
      .NBTN    (8),
      .CLKDIV  (4),
      .NSTABLE (3),
      .NHOLD   (5)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_btn     (btn),
      .o_btn     (o_btn),
      .o_press   (o_press),
      .o_release (o_release),
      .o_hold    (o_hold),
      .o_tick    (o_tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         press_cnt[i] += int'(o_press[i]);
         rel_cnt[i]   += int'(o_release[i]);
      end
   endtask

   task automatic clr_counts();
      for (int i = 0; i < 8; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int tk;
      logic prev_hold;

      clr_counts();

      // Reset with all buttons pressed
      rst_n = 1'b0;
      btn   = 8'hFF;
      repeat (3) cyc();
      chk("rst_btn", 32'(o_btn), 32'h0);
      chk("rst_press", 32'(o_press), 32'h0);
      chk("rst_release", 32'(o_release), 32'h0);
      chk("rst_hold", 32'(o_hold), 32'h0);
      chk("rst_tick", 32'(o_tick), 32'h0);

      rst_n = 1'b1;
      clr_counts();
      n = 0;
      while (o_btn !== 8'hFF && n < 20) begin cyc(); n++; end
      chk("t1_latency", n, 12);
      chk("t1_btn", 32'(o_btn), 32'hFF);
      chk("t1_press", 32'(o_press), 32'hFF);
      cyc();
      chk("t1_press_once", 32'(o_press), 32'h0);
      repeat (40) cyc();
      chk("t1_hold", 32'(o_hold), 32'hFF);

      btn = 8'h00;
      n = 0;
      while (o_btn !== 8'h00 && n < 20) begin cyc(); n++; end
      chk("t1_rel_bound", 32'(n <= 15), 32'h1);
      chk("t1_release", 32'(o_release), 32'hFF);
      chk("t1_hold_drop", 32'(o_hold), 32'h0);
      cyc();
      chk("t1_release_once", 32'(o_release), 32'h0);
      repeat (10) cyc();

      // Bit 0 chatters with a 6-cycle period
      clr_counts();
      for (int k = 0; k < 40; k++) begin
         btn[0] = ((k / 3) % 2 == 0);
         cyc();
         chk("t2_chatter_btn0", 32'(o_btn[0]), 32'h0);
      end
      btn[0] = 1'b1;
      repeat (30) cyc();
      chk("t2_btn0", 32'(o_btn[0]), 32'h1);
      chk("t2_press_cnt", press_cnt[0], 1);
      chk("t2_rel_cnt", rel_cnt[0], 0);

      // Bit 1 long press and hold
      clr_counts();
      btn[1] = 1'b1;
      n = 0;
      while (o_btn[1] !== 1'b1 && n < 20) begin cyc(); n++; end
      chk("t3_rise", 32'(o_btn[1]), 32'h1);
      tk = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         n++;
         if (o_hold[1]) break;
         if (o_tick) tk++;
      end
      chk("t3_hold_ticks", tk, 5);
      chk("t3_hold", 32'(o_hold[1]), 32'h1);
      while (n < 60) begin cyc(); n++; end
      chk("t3_hold_kept", 32'(o_hold[1]), 32'h1);
      btn[1] = 1'b0;
      n = 0;
      prev_hold = o_hold[1];
      while (o_btn[1] !== 1'b0 && n < 20) begin
         prev_hold = o_hold[1];
         cyc();
         n++;
      end
      chk("t3_hold_before_rel", 32'(prev_hold), 32'h1);
      chk("t3_btn_fall", 32'(o_btn[1]), 32'h0);
      chk("t3_hold_fall", 32'(o_hold[1]), 32'h0);
      chk("t3_release", 32'(o_release[1]), 32'h1);
      repeat (5) cyc();
      chk("t3_press_cnt", press_cnt[1], 1);
      chk("t3_rel_cnt", rel_cnt[1], 1);

      // Bits 2 and 3 together
      clr_counts();
      btn[3:2] = 2'b11;
      n = 0;
      while (o_press[3:2] === 2'b00 && n < 20) begin cyc(); n++; end
      chk("t4_press_pair", 32'(o_press[3:2]), 32'h3);
      repeat (10) cyc();
      chk("t4_press_cnt2", press_cnt[2], 1);
      chk("t4_press_cnt3", press_cnt[3], 1);

      // Bit 4: reset after two of three qualifying ticks
      n = 0;
      while (o_tick !== 1'b1 && n < 10) begin cyc(); n++; end
      chk("t5_sync_tick", 32'(o_tick), 32'h1);
      btn[4] = 1'b1;
      tk = 0;
      n = 0;
      while (tk < 2 && n < 20) begin
         cyc();
         n++;
         if (o_tick) tk++;
      end
      chk("t5_two_ticks", tk, 2);
      chk("t5_not_yet", 32'(o_btn[4]), 32'h0);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("t5_async_btn", 32'(o_btn), 32'h0);
      chk("t5_async_press", 32'(o_press), 32'h0);
      chk("t5_async_release", 32'(o_release), 32'h0);
      chk("t5_async_hold", 32'(o_hold), 32'h0);
      chk("t5_async_tick", 32'(o_tick), 32'h0);
      cyc();
      rst_n = 1'b1;
      clr_counts();
      tk = 0;
      n = 0;
      while (n < 20) begin
         cyc();
         n++;
         if (o_btn[4]) break;
         if (o_tick) tk++;
      end
      chk("t5_new_ticks", tk, 3);
      chk("t5_latency", n, 12);
      chk("t5_press", 32'(o_press[4]), 32'h1);

      // Bit 5: 5-cycle glitch spanning one tick
      repeat (30) cyc();
      clr_counts();
      n = 0;
      while (o_tick !== 1'b1 && n < 10) begin cyc(); n++; end
      cyc();
      btn[5] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t6_glitch_btn", 32'(o_btn[5]), 32'h0);
      end
      btn[5] = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         chk("t6_after_btn", 32'(o_btn[5]), 32'h0);
      end
      chk("t6_press_cnt", press_cnt[5], 0);
      chk("t6_rel_cnt", rel_cnt[5], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
